// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - opcodes, FSM state and opcode class helpers for the EX mul/div unit
package ex_muldiv_pkg;

    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_MADD  = 8'b1010_0110;
    localparam logic [7:0] OP_MADDU = 8'b1010_1000;
    localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
    localparam logic [7:0] OP_MSUBU = 8'b1010_1011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_e;

    function automatic logic is_mul(input logic [7:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div(input logic [7:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed(input logic [7:0] op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

    function automatic logic is_acc(input logic [7:0] op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_sub(input logic [7:0] op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - EX-stage request/result bundle between the pipeline and the mul/div unit
interface ex_muldiv_if #(parameter int XLEN = 32) ();

    logic            start;
    logic [7:0]      alu_op;
    logic [XLEN-1:0] src_data1;
    logic [XLEN-1:0] src_data2;
    logic [XLEN-1:0] hi_in;
    logic [XLEN-1:0] lo_in;
    logic            flush;
    logic            stall_req;
    logic            hilo_wr_en;
    logic [XLEN-1:0] hi_data;
    logic [XLEN-1:0] lo_data;
    logic            div_by_zero;

    modport master (
        output start, alu_op, src_data1, src_data2, hi_in, lo_in, flush,
        input  stall_req, hilo_wr_en, hi_data, lo_data, div_by_zero
    );

    modport slave (
        input  start, alu_op, src_data1, src_data2, hi_in, lo_in, flush,
        output stall_req, hilo_wr_en, hi_data, lo_data, div_by_zero
    );

endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - unsigned radix-2 restoring divider, one quotient bit per cycle
// Sign handling is done by the caller; quot_o/rem_o are the values after the current step.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            kill_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    localparam int CW = $clog2(XLEN);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quot_q, rem_q, dvs_q;
    logic [XLEN:0]   shifted, diff;
    logic            ge;
    logic [XLEN-1:0] quot_d, rem_d;

    // Quotient bits shift out of quot_q into the partial remainder as new bits shift in.
    assign shifted = {rem_q, quot_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign ge      = ~diff[XLEN];
    assign rem_d   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quot_d  = {quot_q[XLEN-2:0], ge};

    assign busy_o  = busy_q;
    assign done_o  = busy_q && (cnt_q == CW'(XLEN-1));
    assign quot_o  = quot_d;
    assign rem_o   = rem_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (kill_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            quot_q <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            if (done_o) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - multi-cycle HI/LO multiply, multiply-accumulate and divide engine for EX
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    ex_muldiv_if.slave  bus
);

    localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    md_state_e         state_q;
    logic [7:0]        op_q;
    logic [XLEN-1:0]   src1_q;
    logic              neg_quot_q, neg_rem_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] pipe_q [MUL_CYCLES];
    logic [MCW-1:0]    cnt_q;
    logic              wr_q, dbz_q;
    logic [XLEN-1:0]   hi_q, lo_q;

    logic              accept, sgn, a_neg, b_neg, div_start;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] ext_a, ext_b, prod, mul_res;
    logic              div_busy, div_done;
    logic [XLEN-1:0]   div_quot, div_rem, quot_fix, rem_fix;

    assign accept = (state_q == ST_IDLE) && bus.start && !bus.flush &&
                    (is_mul(bus.alu_op) || is_div(bus.alu_op));

    assign sgn   = is_signed(bus.alu_op);
    assign a_neg = sgn && bus.src_data1[XLEN-1];
    assign b_neg = sgn && bus.src_data2[XLEN-1];
    assign mag_a = a_neg ? -bus.src_data1 : bus.src_data1;
    assign mag_b = b_neg ? -bus.src_data2 : bus.src_data2;

    // A zero divisor never starts the core, so an idle core in DIV marks divide-by-zero.
    assign div_start = accept && is_div(bus.alu_op) && (bus.src_data2 != '0);

    assign ext_a = {{XLEN{a_neg}}, bus.src_data1};
    assign ext_b = {{XLEN{b_neg}}, bus.src_data2};
    assign prod  = ext_a * ext_b;

    assign mul_res = !is_acc(op_q) ? pipe_q[MUL_CYCLES-1] :
                     is_sub(op_q)  ? acc_q - pipe_q[MUL_CYCLES-1] :
                                     acc_q + pipe_q[MUL_CYCLES-1];

    assign quot_fix = neg_quot_q ? -div_quot : div_quot;
    assign rem_fix  = neg_rem_q  ? -div_rem  : div_rem;

    div_iter #(.XLEN(XLEN)) u_div_iter (
        .clk        (clk),
        .reset      (reset),
        .kill_i     (bus.flush),
        .start_i    (div_start),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            src1_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            for (int k = 0; k < MUL_CYCLES; k++) pipe_q[k] <= '0;
        end else begin
            wr_q  <= 1'b0;
            dbz_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
            if (bus.flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: if (accept) begin
                        op_q       <= bus.alu_op;
                        src1_q     <= bus.src_data1;
                        neg_quot_q <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        acc_q      <= {bus.hi_in, bus.lo_in};
                        pipe_q[0]  <= prod;
                        cnt_q      <= '0;
                        state_q    <= is_div(bus.alu_op) ? ST_DIV : ST_MUL;
                    end
                    ST_MUL: if (cnt_q == MCW'(MUL_CYCLES-1)) begin
                        state_q      <= ST_DONE;
                        wr_q         <= 1'b1;
                        {hi_q, lo_q} <= mul_res;
                    end else begin
                        cnt_q <= cnt_q + MCW'(1);
                        for (int k = MUL_CYCLES-1; k > 0; k--) pipe_q[k] <= pipe_q[k-1];
                    end
                    ST_DIV: if (!div_busy) begin
                        state_q <= ST_DONE;
                        wr_q    <= 1'b1;
                        dbz_q   <= 1'b1;
                        hi_q    <= src1_q;
                        lo_q    <= '1;
                    end else if (div_done) begin
                        state_q <= ST_DONE;
                        wr_q    <= 1'b1;
                        hi_q    <= rem_fix;
                        lo_q    <= quot_fix;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.stall_req   = !bus.flush && (accept || state_q == ST_MUL || state_q == ST_DIV);
    assign bus.hilo_wr_en  = wr_q;
    assign bus.hi_data     = hi_q;
    assign bus.lo_data     = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed vector bench for ex_muldiv_unit (XLEN=32, MUL_CYCLES=2)
module tb_ex_muldiv_unit;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(32)) bus ();

    ex_muldiv_unit #(.XLEN(32), .MUL_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [31:0] ehi, elo;
        logic        edbz;
        int          elat;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [7:0] op, input logic [31:0] a, b, hi, lo,
                       input logic [31:0] ehi, elo, input logic edbz, input int elat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
        v.ehi = ehi; v.elo = elo; v.edbz = edbz; v.elat = elat;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, b, hi, lo);
        bus.start     = 1'b1;
        bus.alu_op    = op;
        bus.src_data1 = a;
        bus.src_data2 = b;
        bus.hi_in     = hi;
        bus.lo_in     = lo;
    endtask

    // Cycle 0 is the issue cycle; returns one cycle after the strobe (or when the budget runs out).
    task automatic run_vec(input vec_t v, input logic hold);
        logic        seen = 1'b0;
        int          lat = -1, stalls = 0;
        logic [31:0] hi = '0, lo = '0;
        logic        dbz = 1'b0, strobe_stall = 1'b0;
        issue(v.op, v.a, v.b, v.hi, v.lo);
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (bus.hilo_wr_en) begin
                seen = 1'b1; lat = c; hi = bus.hi_data; lo = bus.lo_data;
                dbz = bus.div_by_zero; strobe_stall = bus.stall_req;
            end else if (bus.stall_req) begin
                stalls++;
            end
            step();
            if (hold && !seen) issue(OP_MULTU, 32'd7, 32'd7, 32'd0, 32'd0);
            else bus.start = 1'b0;
        end
        check({v.name, "_latency"}, 32'(lat), 32'(v.elat));
        check({v.name, "_stalls"}, 32'(stalls), 32'(v.elat));
        check({v.name, "_hi"}, hi, v.ehi);
        check({v.name, "_lo"}, lo, v.elo);
        check({v.name, "_dbz"}, 32'(dbz), 32'(v.edbz));
        check({v.name, "_strobe_stall"}, 32'(strobe_stall), 32'd0);
        @(negedge clk);
        check({v.name, "_one_cycle"}, 32'(bus.hilo_wr_en), 32'd0);
        step();
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int strobes = 0, stalls = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.hilo_wr_en) strobes++;
            if (bus.stall_req) stalls++;
            step();
        end
        check({name, "_no_strobe"}, 32'(strobes), 32'd0);
        check({name, "_no_stall"}, 32'(stalls), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hv;
        reset = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.alu_op = '0;
        bus.src_data1 = '0; bus.src_data2 = '0; bus.hi_in = '0; bus.lo_in = '0;

        add("mult_m3x5",   OP_MULT,  32'hFFFFFFFD, 32'd5,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 3);
        add("multu_max2",  OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'd0, 32'd0,        32'h00000001, 32'hFFFFFFFE, 1'b0, 3);
        add("multu_maxsq", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,        32'hFFFFFFFE, 32'h00000001, 1'b0, 3);
        add("mult_minsq",  OP_MULT,  32'h80000000, 32'h80000000, 32'd0, 32'd0,        32'h40000000, 32'h00000000, 1'b0, 3);
        add("madd_2x3",    OP_MADD,  32'd2,        32'd3,        32'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000005, 1'b0, 3);
        add("maddu_max",   OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1,        32'hFFFFFFFE, 32'h00000002, 1'b0, 3);
        add("msub_1x1",    OP_MSUB,  32'd1,        32'd1,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3);
        add("msubu_3x4",   OP_MSUBU, 32'd3,        32'd4,        32'd0, 32'd10,       32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 3);
        add("div_m7_2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        add("div_7_m2",    OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd0, 32'd0,        32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
        add("div_m8_m3",   OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'd0, 32'd0,        32'hFFFFFFFE, 32'h00000002, 1'b0, 33);
        add("divu_7_2",    OP_DIVU,  32'd7,        32'd2,        32'd0, 32'd0,        32'h00000001, 32'h00000003, 1'b0, 33);
        add("div_min_m1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,        32'h00000000, 32'h80000000, 1'b0, 33);
        add("divu_5_0",    OP_DIVU,  32'd5,        32'd0,        32'd0, 32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 2);
        add("div_m7_0",    OP_DIV,   32'hFFFFFFF9, 32'd0,        32'd0, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_wr_en", 32'(bus.hilo_wr_en), 32'd0);
        check("reset_stall", 32'(bus.stall_req), 32'd0);
        check("reset_hi", bus.hi_data, 32'd0);
        check("reset_lo", bus.lo_data, 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        step();

        foreach (vecs[i]) run_vec(vecs[i], 1'b0);

        // start held with different operands while busy must not disturb the running MULT
        hv.name = "hold_mult_3x3"; hv.op = OP_MULT; hv.a = 32'd3; hv.b = 32'd3; hv.hi = '0; hv.lo = '0;
        hv.ehi = 32'd0; hv.elo = 32'd9; hv.edbz = 1'b0; hv.elat = 3;
        run_vec(hv, 1'b1);

        // unlisted opcode is not accepted
        issue(8'h20, 32'd1, 32'd1, 32'd0, 32'd0);
        @(negedge clk);
        check("bad_op_stall", 32'(bus.stall_req), 32'd0);
        step();
        bus.start = 1'b0;
        expect_quiet("bad_op", 10);

        // flush together with start in IDLE is not accepted
        issue(OP_MULT, 32'd2, 32'd2, 32'd0, 32'd0);
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_start_stall", 32'(bus.stall_req), 32'd0);
        step();
        bus.start = 1'b0; bus.flush = 1'b0;
        expect_quiet("flush_start", 8);

        // flush during DIV cycle 10
        issue(OP_DIVU, 32'd7, 32'd2, 32'd0, 32'd0);
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_div_stall_drop", 32'(bus.stall_req), 32'd0);
        step();
        bus.flush = 1'b0;
        expect_quiet("flush_div", 40);

        // reset during MUL cycle 1
        issue(OP_MULT, 32'd5, 32'd6, 32'd0, 32'd0);
        step();
        bus.start = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mul_wr_en", 32'(bus.hilo_wr_en), 32'd0);
        check("rst_mul_stall", 32'(bus.stall_req), 32'd0);
        check("rst_mul_lo", bus.lo_data, 32'd0);
        step();
        expect_quiet("rst_mul", 8);

        hv.name = "after_mult_2x2"; hv.op = OP_MULT; hv.a = 32'd2; hv.b = 32'd2; hv.hi = '0; hv.lo = '0;
        hv.ehi = 32'd0; hv.elo = 32'd4; hv.edbz = 1'b0; hv.elat = 3;
        run_vec(hv, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
